// File: rtl/route_lookup_arbiter.sv
// Round-robin arbiter sharing one routing_table read port among the router input ports.
// Grants one port per lookup and returns the looked-up direction with a one-cycle valid pulse.
module route_lookup_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_W    = 4,
    parameter int DIR_W     = 3,
    parameter int NUM_NODES = 9,
    parameter int DIR_LOCAL = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]           table_addr,
    input  logic [DIR_W-1:0]            table_data,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic [DIR_W-1:0]            resp_dir,
    output logic                        resp_err,
    output logic                        busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOOKUP = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   win_r;
    logic [PTR_W-1:0]   win_next_s;
    logic [PTR_W-1:0]   ptr_next_s;
    logic [NUM_PORTS-1:0] eligible_s;
    logic               grant_s;
    logic [ADDR_W-1:0]  addr_next_s;
    logic [ADDR_W-1:0]  addr_s [NUM_PORTS];
    logic               in_range_s;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_addr
        assign addr_s[p] = req_addr[p*ADDR_W +: ADDR_W];
    end

    // A port whose response is on the outputs right now must not win again this edge
    assign eligible_s = req & ~resp_valid;

    // Round-robin search from ptr_r upward; descending loop so the nearest eligible port wins
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        idx_v       = {PTR_W{1'b0}};
        grant_s     = 1'b0;
        win_next_s  = win_r;
        addr_next_s = table_addr;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx_v       = ((int'(ptr_r) + i) >= NUM_PORTS) ? PTR_W'(int'(ptr_r) + i - NUM_PORTS)
                                                           : PTR_W'(int'(ptr_r) + i);
            grant_s     = grant_s | eligible_s[idx_v];
            win_next_s  = eligible_s[idx_v] ? idx_v : win_next_s;
            addr_next_s = eligible_s[idx_v] ? addr_s[idx_v] : addr_next_s;
        end
    end

    // Pointer wrap compares against the last index so a non-power-of-2 port count never overflows
    always_comb begin
        ptr_next_s = (win_r == PTR_W'(NUM_PORTS - 1)) ? {PTR_W{1'b0}} : (win_r + PTR_W'(1));
        in_range_s = (32'(table_addr) < NUM_NODES);
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = grant_s ? LOOKUP : IDLE;
            LOOKUP:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered outputs; reset discards any in-flight lookup
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= {PTR_W{1'b0}};
            win_r      <= {PTR_W{1'b0}};
            table_addr <= {ADDR_W{1'b0}};
            resp_valid <= {NUM_PORTS{1'b0}};
            resp_dir   <= {DIR_W{1'b0}};
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == LOOKUP);
            case (state_r)
                IDLE: begin
                    resp_valid <= {NUM_PORTS{1'b0}};
                    resp_err   <= 1'b0;
                    win_r      <= win_next_s;
                    table_addr <= addr_next_s;
                end
                LOOKUP: begin
                    resp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_r;
                    resp_dir   <= in_range_s ? table_data : DIR_W'(DIR_LOCAL);
                    resp_err   <= ~in_range_s;
                    ptr_r      <= ptr_next_s;
                end
                default: begin
                    resp_valid <= {NUM_PORTS{1'b0}};
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/route_lookup_arbiter.md
# route_lookup_arbiter

Shares the single read port of a node's `routing_table` among the router's input ports. Each input port presents a destination node address; the arbiter grants one port at a time in round-robin order, drives the table address, and captures the returned output direction. It returns the direction to the granted port with a one-cycle valid pulse. It sits between the per-port input buffers and the `routing_table` instance inside each router.

## Interface
- NUM_PORTS, 5, number of requesting input ports (N, E, S, W, local)
- ADDR_W, 4, destination address width (matches `ADDR_SZ`)
- DIR_W, 3, direction code width (matches `BITS_DIR`)
- NUM_NODES, 9, valid destination range is 0..NUM_NODES-1
- DIR_LOCAL, 4, direction code returned for out-of-range addresses
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- req  in  NUM_PORTS  per-port lookup request, level, held until the port's resp_valid
- req_addr  in  NUM_PORTS*ADDR_W  per-port destination; port p occupies bits [p*ADDR_W +: ADDR_W]
- table_addr  out  ADDR_W  registered address to `routing_table`
- table_data  in  DIR_W  combinational read data from `routing_table`
- resp_valid  out  NUM_PORTS  one-hot, one-cycle pulse to the served port
- resp_dir  out  DIR_W  looked-up direction, valid while resp_valid is non-zero
- resp_err  out  1  pulses with resp_valid when the served address is ≥ NUM_NODES
- busy  out  1  high while in state LOOKUP

## Operation
- Two-state FSM: IDLE, LOOKUP.
- IDLE, eligible = req & ~resp_valid. The mask keeps a port whose response is being presented this cycle from being granted again.
  - If eligible ≠ 0: select the winner by round-robin search starting at ptr, ascending, wrapping at NUM_PORTS-1→0.
  - Register the winner index in win and its req_addr in table_addr, then go to LOOKUP.
  - If eligible = 0: stay in IDLE; table_addr holds its value.
- LOOKUP:
  - If table_addr < NUM_NODES: resp_dir ← table_data, resp_err ← 0.
  - Otherwise: resp_dir ← DIR_LOCAL, resp_err ← 1.
  - resp_valid ← one-hot(win).
  - ptr ← (win+1) mod NUM_PORTS. The comparison must not overflow when NUM_PORTS is not a power of 2.
  - Go to IDLE.
- resp_valid and resp_err clear on the next edge after assertion. resp_dir holds its last value.
- If the winner drops req during LOOKUP, the lookup still completes and resp_valid still pulses. The pointer advances normally.
- req_addr of the winner is sampled only on the IDLE→LOOKUP edge. Later changes are ignored.
- Reset, asynchronous, any state:
  - state = IDLE, ptr = 0, win = 0, table_addr = 0, resp_valid = 0, resp_dir = 0, resp_err = 0, busy = 0.
  - An in-flight lookup is discarded and no response is issued.
- Table contents load on the reset rising edge, so no post-reset wait is required.

## Timing
- Edge k: IDLE with eligible ≠ 0 → grant, table_addr updated, busy = 1.
- Edge k+1: resp_valid/resp_dir/resp_err registered, busy = 0.
- Edge k+2: earliest next grant. Maximum throughput is one lookup per 2 cycles.
- Latency from req first seen in IDLE to resp_valid is 2 edges.
- A requester samples resp_valid at edge k+2 and may drop req afterward. The mask prevents a duplicate grant at edge k+2.
- Worst-case wait for any port with all ports requesting: 2·NUM_PORTS cycles.
- table_data must settle within one cycle of table_addr (it is combinational).

## Test plan
- Single request, node-0 table, port 2, req_addr=3 → table_addr=3 after 1 edge; resp_valid=5'b00100 and resp_dir=2 after 2 edges; busy high exactly 1 cycle.
- All 5 ports request continuously, ptr=0 → grants in order 0,1,2,3,4,0 with resp_valid every 2nd cycle; no port repeated while others wait.
- Port 1 holds req through its resp_valid cycle and drops next → exactly one resp_valid for port 1, then port 3 (also requesting) served next; no duplicate.
- req_addr=12 (≥ NUM_NODES) → resp_dir=4, resp_err=1 for one cycle, then 0.
- Reset asserted during LOOKUP → all outputs 0 immediately, no resp_valid after release; first grant after release goes to the lowest requesting port (ptr=0).
- Winner changes req_addr from 5 to 7 during LOOKUP → response uses 5 (node-1 table: resp_dir=1).
